// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 timing constants, colour codes and a range helper
package vga_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int CNT_W = 10;

    localparam logic [5:0] COLOR_GOLD  = 6'b110110;
    localparam logic [5:0] COLOR_BLACK = 6'b000000;

    // Inclusive unsigned window test used for the sync pulse decode.
    function automatic logic in_range(input logic [CNT_W-1:0] val, input int lo, input int hi);
        return (val >= CNT_W'(lo)) && (val <= CNT_W'(hi));
    endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// rtl/vga_sync_counter.sv - h/v raster counters, frame counter, sync and active decode
module vga_sync_counter
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_ce,
    output logic [CNT_W-1:0] h,
    output logic [CNT_W-1:0] v,
    output logic [7:0]       frame_cnt,
    output logic             active,
    output logic             hs_raw,
    output logic             vs_raw,
    output logic             frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            h         <= '0;
            v         <= '0;
            frame_cnt <= '0;
        end else if (pix_ce) begin
            if (h == H_LAST) begin
                h <= '0;
                if (v == V_LAST) begin
                    v         <= '0;
                    frame_cnt <= frame_cnt + 8'd1;
                end else begin
                    v <= v + 1'b1;
                end
            end else begin
                h <= h + 1'b1;
            end
        end
    end

    assign active      = (h < CNT_W'(H_ACTIVE)) && (v < CNT_W'(V_ACTIVE));
    assign hs_raw      = in_range(h, H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC - 1);
    assign vs_raw      = in_range(v, V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC - 1);
    assign frame_start = pix_ce && (h == '0) && (v == '0);

endmodule

// File: rtl/vga_overlay_timing.sv
// rtl/vga_overlay_timing.sv - raster source for overlays plus one-stage RGB222/sync output register
module vga_overlay_timing
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit SYNC_NEG = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_ce,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             active,
    output logic             frame_start,
    output logic [7:0]       frame_cnt,
    input  logic             ovl_draw,
    input  logic [5:0]       ovl_rgb,
    input  logic [5:0]       bg_rgb,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [5:0]       rgb_out
);

    logic hs_raw;
    logic vs_raw;

    vga_sync_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_sync_counter (
        .clk         (clk),
        .rst         (rst),
        .pix_ce      (pix_ce),
        .h           (x),
        .v           (y),
        .frame_cnt   (frame_cnt),
        .active      (active),
        .hs_raw      (hs_raw),
        .vs_raw      (vs_raw),
        .frame_start (frame_start)
    );

    // Sync, data-enable and colour all come from the same counter values so they stay aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync   <= SYNC_NEG;
            vsync   <= SYNC_NEG;
            de      <= 1'b0;
            rgb_out <= COLOR_BLACK;
        end else if (pix_ce) begin
            hsync   <= hs_raw ^ SYNC_NEG;
            vsync   <= vs_raw ^ SYNC_NEG;
            de      <= active;
            rgb_out <= !active ? COLOR_BLACK : (ovl_draw ? ovl_rgb : bg_rgb);
        end
    end

endmodule

// File: tb/tb_vga_overlay_timing.sv
// tb/tb_vga_overlay_timing.sv - directed self-checking bench on a shrunken raster
module tb_vga_overlay_timing;

    localparam int HA = 12, HF = 2, HS = 3, HB = 3, HT = 20;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 1, VT = 10;
    localparam logic [9:0] OX = 10'd5, OY = 10'd3;
    localparam logic [9:0] BX = 10'd13;
    localparam logic [5:0] GOLD = 6'b110110;
    localparam logic [5:0] JUNK = 6'b101010;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pix_ce = 1'b0;
    logic [9:0] x, y;
    logic       active, frame_start;
    logic [7:0] frame_cnt;
    logic       ovl_draw;
    logic [5:0] ovl_rgb;
    logic [5:0] bg_rgb = 6'b000011;
    logic       hsync, vsync, de;
    logic [5:0] rgb_out;
    logic       ovl_en = 1'b0;

    int nvec = 0;
    int nerr = 0;

    logic [9:0] mh, mv;
    logic [7:0] mfc;
    logic       mhs, mvs, mde;
    logic [5:0] mrgb;

    always #5 clk = ~clk;

    assign ovl_draw = ovl_en && (((x == OX) && (y == OY)) || ((x == BX) && (y == OY)));
    assign ovl_rgb  = ovl_draw ? GOLD : JUNK;

    vga_overlay_timing #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_NEG (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_ce      (pix_ce),
        .x           (x),
        .y           (y),
        .active      (active),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt),
        .ovl_draw    (ovl_draw),
        .ovl_rgb     (ovl_rgb),
        .bg_rgb      (bg_rgb),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .rgb_out     (rgb_out)
    );

    // One clock of stimulus; the reference raster is advanced alongside it.
    task automatic advance(input logic ce, input logic r);
        logic act, hit;
        pix_ce = ce;
        rst    = r;
        act = (mh < 10'(HA)) && (mv < 10'(VA));
        hit = ovl_en && (((mh == OX) && (mv == OY)) || ((mh == BX) && (mv == OY)));
        @(posedge clk);
        #1;
        if (r) begin
            mh = '0; mv = '0; mfc = '0;
            mhs = 1'b1; mvs = 1'b1; mde = 1'b0; mrgb = '0;
        end else if (ce) begin
            mde  = act;
            mrgb = !act ? 6'b0 : (hit ? GOLD : bg_rgb);
            mhs  = !((mh >= 10'(HA + HF)) && (mh <= 10'(HA + HF + HS - 1)));
            mvs  = !((mv >= 10'(VA + VF)) && (mv <= 10'(VA + VF + VS - 1)));
            if (mh == 10'(HT - 1)) begin
                mh = '0;
                if (mv == 10'(VT - 1)) begin
                    mv  = '0;
                    mfc = mfc + 8'd1;
                end else begin
                    mv = mv + 10'd1;
                end
            end else begin
                mh = mh + 10'd1;
            end
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) advance(1'b1, 1'b1);
        nvec++;
        if ({x, y} !== {10'd0, 10'd0}) begin
            nerr++; $display("FAIL reset_xy: got x=%0d y=%0d, want 0 0", x, y);
        end
        nvec++;
        if ({active, frame_start} !== 2'b11) begin
            nerr++; $display("FAIL reset_active_fs: got %b%b, want 11", active, frame_start);
        end
        nvec++;
        if ({hsync, vsync, de, rgb_out, frame_cnt} !== {1'b1, 1'b1, 1'b0, 6'd0, 8'd0}) begin
            nerr++; $display("FAIL reset_pins: got hs=%b vs=%b de=%b rgb=%b fc=%0d, want 1 1 0 000000 0",
                             hsync, vsync, de, rgb_out, frame_cnt);
        end
    endtask

    task automatic test_line;
        int hs_low = 0;
        for (int i = 0; i < HT; i++) begin
            advance(1'b1, 1'b0);
            if (hsync == 1'b0) hs_low++;
            nvec++;
            if ({hsync, vsync, de, rgb_out} !== {mhs, mvs, mde, mrgb}) begin
                nerr++; $display("FAIL line_pins@%0d: got %b%b%b%b, want %b%b%b%b", i,
                                 hsync, vsync, de, rgb_out, mhs, mvs, mde, mrgb);
            end
            if (i == HT - 2) begin
                nvec++;
                if (x !== 10'(HT - 1)) begin
                    nerr++; $display("FAIL line_last_x: got %0d, want %0d", x, HT - 1);
                end
            end
        end
        nvec++;
        if (hs_low != HS) begin
            nerr++; $display("FAIL line_hs_width: got %0d, want %0d", hs_low, HS);
        end
        nvec++;
        if ({x, y} !== {10'd0, 10'd1}) begin
            nerr++; $display("FAIL line_wrap: got x=%0d y=%0d, want 0 1", x, y);
        end
    endtask

    task automatic test_frame;
        int vs_low = 0;
        int fs_cnt = 0;
        for (int i = 0; i < (VT - 1) * HT; i++) begin
            advance(1'b1, 1'b0);
            if (vsync == 1'b0) vs_low++;
        end
        nvec++;
        if (vs_low != VS * HT) begin
            nerr++; $display("FAIL frame_vs_width: got %0d, want %0d", vs_low, VS * HT);
        end
        nvec++;
        if ({frame_start, frame_cnt} !== {1'b1, 8'd1}) begin
            nerr++; $display("FAIL frame_first: got fs=%b fc=%0d, want 1 1", frame_start, frame_cnt);
        end
        for (int f = 0; f < 255; f++) begin
            for (int i = 0; i < VT * HT; i++) begin
                if (frame_start) fs_cnt++;
                advance(1'b1, 1'b0);
            end
            if (f == 253) begin
                nvec++;
                if (frame_cnt !== 8'd255) begin
                    nerr++; $display("FAIL frame_cnt_255: got %0d, want 255", frame_cnt);
                end
            end
        end
        nvec++;
        if (fs_cnt != 255) begin
            nerr++; $display("FAIL frame_start_count: got %0d, want 255", fs_cnt);
        end
        nvec++;
        if (frame_cnt !== 8'd0) begin
            nerr++; $display("FAIL frame_cnt_wrap: got %0d, want 0", frame_cnt);
        end
    endtask

    task automatic test_overlay;
        int n_gold = 0, n_bg = 0, n_blank_bad = 0;
        ovl_en = 1'b1;
        bg_rgb = 6'b000011;
        for (int i = 0; i < VT * HT; i++) begin
            advance(1'b1, 1'b0);
            if (rgb_out == GOLD) n_gold++;
            if (rgb_out == 6'b000011) n_bg++;
            if (!de && rgb_out != 6'd0) n_blank_bad++;
            nvec++;
            if ({de, rgb_out} !== {mde, mrgb}) begin
                nerr++; $display("FAIL ovl_pix@%0d: got de=%b rgb=%b, want de=%b rgb=%b",
                                 i, de, rgb_out, mde, mrgb);
            end
        end
        nvec++;
        if (n_gold != 1) begin
            nerr++; $display("FAIL ovl_gold_count: got %0d, want 1", n_gold);
        end
        nvec++;
        if (n_bg != HA * VA - 1) begin
            nerr++; $display("FAIL ovl_bg_count: got %0d, want %0d", n_bg, HA * VA - 1);
        end
        nvec++;
        if (n_blank_bad != 0) begin
            nerr++; $display("FAIL ovl_blanking: got %0d nonzero blank pixels, want 0", n_blank_bad);
        end
    endtask

    task automatic test_ce_toggle;
        logic [38:0] held;
        for (int i = 0; i < 4 * HT; i++) begin
            held = {x, y, hsync, vsync, de, rgb_out, frame_cnt};
            advance(i[0] == 1'b0, 1'b0);
            nvec++;
            if (i[0]) begin
                if ({x, y, hsync, vsync, de, rgb_out, frame_cnt} !== held) begin
                    nerr++; $display("FAIL ce_hold@%0d: got %h, want %h", i,
                                     {x, y, hsync, vsync, de, rgb_out, frame_cnt}, held);
                end
            end else if ({x, y, hsync, vsync, de, rgb_out} !== {mh, mv, mhs, mvs, mde, mrgb}) begin
                nerr++; $display("FAIL ce_step@%0d: got x=%0d y=%0d rgb=%b, want x=%0d y=%0d rgb=%b",
                                 i, x, y, rgb_out, mh, mv, mrgb);
            end
        end
        nvec++;
        if ({x, y} !== {10'd0, 10'd2}) begin
            nerr++; $display("FAIL ce_position: got x=%0d y=%0d, want 0 2", x, y);
        end
    endtask

    task automatic test_reset_mid;
        int guard = 0;
        while (!(x == 10'd7 && y == 10'd4) && guard < 500) begin
            advance(1'b1, 1'b0);
            guard++;
        end
        nvec++;
        if (guard >= 500) begin
            nerr++; $display("FAIL mid_reach: got timeout at x=%0d y=%0d, want x=7 y=4", x, y);
        end
        nvec++;
        if ({de, rgb_out} !== {1'b1, 6'b000011}) begin
            nerr++; $display("FAIL mid_before: got de=%b rgb=%b, want 1 000011", de, rgb_out);
        end
        advance(1'b1, 1'b1);
        nvec++;
        if ({x, y, rgb_out, de, hsync, vsync, frame_cnt} !==
            {10'd0, 10'd0, 6'd0, 1'b0, 1'b1, 1'b1, 8'd0}) begin
            nerr++; $display("FAIL mid_reset: got x=%0d y=%0d rgb=%b de=%b hs=%b vs=%b fc=%0d, want 0 0 000000 0 1 1 0",
                             x, y, rgb_out, de, hsync, vsync, frame_cnt);
        end
        rst = 1'b0;
        #1;
        nvec++;
        if (frame_start !== 1'b1) begin
            nerr++; $display("FAIL mid_frame_start: got %b, want 1", frame_start);
        end
        advance(1'b1, 1'b0);
        nvec++;
        if ({x, de, rgb_out} !== {10'd1, 1'b1, 6'b000011}) begin
            nerr++; $display("FAIL mid_restart: got x=%0d de=%b rgb=%b, want 1 1 000011", x, de, rgb_out);
        end
    endtask

    initial begin
        mh = '0; mv = '0; mfc = '0;
        mhs = 1'b1; mvs = 1'b1; mde = 1'b0; mrgb = '0;
        test_reset;
        test_line;
        test_frame;
        test_overlay;
        test_ce_toggle;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
